// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder and its tick generator.
// The default tick period is shared with other ms-based timers.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TICK_CYCLES = 100000;

endpackage

// File: rtl/button_event_decoder_tick_gen.sv
// Clearable ms prescaler: one-cycle tick on the terminal count while enabled.
// Held at zero whenever it is disabled or cleared.
module event_tick_gen
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned TW =
        (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TERM = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic          term;

    assign term   = (cnt_q == TERM);
    assign tick_o = enable_i & term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (term) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long-press/repeat pulses.
// All event outputs are registered and mutually exclusive.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_level_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int unsigned MS_W  = $clog2(LONG_MS + 1);
    localparam int unsigned REP_W = $clog2(REPEAT_MS + 1);
    localparam logic [MS_W-1:0]  LONG_C = MS_W'(LONG_MS);
    localparam logic [REP_W-1:0] REP_C  = REP_W'(REPEAT_MS);

    state_e state_q, state_d;
    logic [MS_W-1:0]  ms_q, ms_d, ms_inc;
    logic [REP_W-1:0] rep_q, rep_d, rep_inc;
    logic btn_q;
    logic press_q, press_d;
    logic release_q, release_d;
    logic long_q, long_d;
    logic rpt_q, rpt_d;
    logic held_q, held_d;
    logic rise, fall, tick, tick_en;

    assign rise    = btn_level_i & ~btn_q;
    assign fall    = ~btn_level_i & btn_q;
    assign tick_en = (state_q != IDLE);
    assign ms_inc  = ms_q + 1'b1;
    assign rep_inc = rep_q + 1'b1;

    event_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clock   (clock),
        .reset   (reset),
        .clear_i (rise),
        .enable_i(tick_en),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;
        held_d    = held_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    ms_d    = '0;
                    rep_d   = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // A fall always beats a same-cycle long_press.
                if (fall) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    ms_d      = '0;
                    rep_d     = '0;
                    state_d   = IDLE;
                end else if (tick) begin
                    ms_d = ms_inc;
                    if (ms_inc == LONG_C) begin
                        long_d  = 1'b1;
                        rep_d   = '0;
                        state_d = LONG_HELD;
                    end
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    ms_d      = '0;
                    rep_d     = '0;
                    state_d   = IDLE;
                end else if (tick) begin
                    if (rep_inc == REP_C) begin
                        rpt_d = 1'b1;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                held_d  = 1'b0;
                ms_d    = '0;
                rep_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ms_q      <= '0;
            rep_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            rep_q     <= rep_d;
            btn_q     <= btn_level_i;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
            held_q    <= held_d;
        end
    end

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign repeat_o     = rpt_q;
    assign held_o       = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a 10-cycle tick,
// LONG_MS=5 and REPEAT_MS=2.
module tb_button_event_decoder;

    localparam int TICK = 10;
    localparam int LMS  = 5;
    localparam int RMS  = 2;
    localparam int LONG_AT = TICK * LMS;
    localparam int REP_P   = TICK * RMS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic press, rel, lng, rpt, held;

    int checks = 0;
    int errors = 0;

    // Packed expectation order: {press, release, long_press, repeat, held}
    typedef struct packed {
        logic       rst;
        logic       btn;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [17];

    button_event_decoder #(
        .TICK_CYCLES(TICK),
        .LONG_MS    (LMS),
        .REPEAT_MS  (RMS)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .btn_level_i (btn),
        .press_o     (press),
        .release_o   (rel),
        .long_press_o(lng),
        .repeat_o    (rpt),
        .held_o      (held)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic b);
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [4:0] exp);
        logic [4:0] got;
        got = {press, rel, lng, rpt, held};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b exp %b", nm, idx, got, exp);
        end
    endtask

    // Hold the button for n samples starting from idle, checking every cycle.
    task automatic hold(input string nm, input int n, input bit do_rel);
        logic [4:0] e;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
            e = 5'b00001;
            if (i == 0) e[4] = 1'b1;
            if (i == LONG_AT) e[2] = 1'b1;
            if (i > LONG_AT && ((i - LONG_AT) % REP_P) == 0)
                e[1] = 1'b1;
            chk(nm, i, e);
        end
        if (do_rel) begin
            step(1'b0, 1'b0);
            chk(nm, n, 5'b01000);
            step(1'b0, 1'b0);
            chk(nm, n + 1, 5'b00000);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 5'b00000};
        vecs[1]  = '{1'b1, 1'b0, 5'b00000};
        vecs[2]  = '{1'b1, 1'b0, 5'b00000};
        vecs[3]  = '{1'b0, 1'b0, 5'b00000};
        vecs[4]  = '{1'b0, 1'b1, 5'b10001};
        vecs[5]  = '{1'b0, 1'b0, 5'b01000};
        vecs[6]  = '{1'b0, 1'b0, 5'b00000};
        vecs[7]  = '{1'b0, 1'b1, 5'b10001};
        vecs[8]  = '{1'b0, 1'b1, 5'b00001};
        vecs[9]  = '{1'b0, 1'b1, 5'b00001};
        vecs[10] = '{1'b0, 1'b0, 5'b01000};
        vecs[11] = '{1'b0, 1'b0, 5'b00000};
        vecs[12] = '{1'b0, 1'b1, 5'b10001};
        vecs[13] = '{1'b1, 1'b1, 5'b00000};
        vecs[14] = '{1'b0, 1'b1, 5'b10001};
        vecs[15] = '{1'b0, 1'b0, 5'b01000};
        vecs[16] = '{1'b0, 1'b0, 5'b00000};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].btn);
            chk("vec", i, vecs[i].exp);
        end

        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            chk("idle", i, 5'b00000);
        end

        hold("short", 20, 1'b1);
        hold("long", 120, 1'b1);
        hold("collide", LONG_AT, 1'b1);

        hold("midrst", 30, 1'b0);
        step(1'b1, 1'b1);
        chk("midrst_rst", 0, 5'b00000);
        step(1'b1, 1'b1);
        chk("midrst_rst", 1, 5'b00000);
        hold("after_rst", 60, 1'b1);

        hold("glitch", 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
